// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction memory address and streams
// fetched instructions to decode through a valid/ready output register.
//
// After reset the PC is loaded from the reset vector slot. An interrupt loads it from the
// interrupt vector slot. The memory read is asynchronous: data is valid in the same cycle
// as the address.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_ni         synchronous active-low reset
//   imem_addr_o    instruction memory address (combinational from state / PC)
//   imem_data_i    instruction memory read data (same cycle)
//   ifu_valid_o    ifu_instr_o / ifu_pc_o hold a fetched instruction
//   ifu_ready_i    decode accepts the held instruction this cycle
//   ifu_instr_o    fetched instruction
//   ifu_pc_o       address the held instruction was fetched from
//   redir_valid_i  branch/jump redirect request
//   redir_pc_i     redirect target
//   intr_req_i     interrupt request pulse
//   intr_ack_o     one-cycle pulse when an interrupt is taken
//   int_ret_pc_o   return address captured when the interrupt is taken
//
// DATA_W must be >= ADDR_W: a vector is the low ADDR_W bits of the memory word.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W       = 8,
    parameter int unsigned       DATA_W       = 8,
    parameter logic [ADDR_W-1:0] RST_VEC_ADDR = ADDR_W'(8'h00),
    parameter logic [ADDR_W-1:0] INT_VEC_ADDR = ADDR_W'(8'h01)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [DATA_W-1:0] imem_data_i,
    output logic              ifu_valid_o,
    input  logic              ifu_ready_i,
    output logic [DATA_W-1:0] ifu_instr_o,
    output logic [ADDR_W-1:0] ifu_pc_o,
    input  logic              redir_valid_i,
    input  logic [ADDR_W-1:0] redir_pc_i,
    input  logic              intr_req_i,
    output logic              intr_ack_o,
    output logic [ADDR_W-1:0] int_ret_pc_o
);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StInt
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              pending_q;
    logic              ifu_valid_q;
    logic [DATA_W-1:0] ifu_instr_q;
    logic [ADDR_W-1:0] ifu_pc_q;
    logic              intr_ack_q;
    logic [ADDR_W-1:0] int_ret_pc_q;

    logic [ADDR_W-1:0] vector;
    logic              advance;

    assign vector  = imem_data_i[ADDR_W-1:0];
    // The output register can take a new instruction when empty or being drained.
    assign advance = !ifu_valid_q || ifu_ready_i;

    always_comb begin
        imem_addr_o = pc_q;
        case (state_q)
            StBoot:  imem_addr_o = RST_VEC_ADDR;
            StInt:   imem_addr_o = INT_VEC_ADDR;
            default: imem_addr_o = pc_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StBoot;
            pc_q         <= '0;
            pending_q    <= 1'b0;
            ifu_valid_q  <= 1'b0;
            ifu_instr_q  <= '0;
            ifu_pc_q     <= '0;
            intr_ack_q   <= 1'b0;
            int_ret_pc_q <= '0;
        end else begin
            intr_ack_q <= 1'b0;
            // Requests collapse into one pending flag; a take below overrides this set.
            if (intr_req_i) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                StBoot: begin
                    pc_q    <= vector;
                    state_q <= StRun;
                end
                StInt: begin
                    pc_q    <= vector;
                    state_q <= StRun;
                end
                StRun: begin
                    if (redir_valid_i) begin
                        // Flush the held instruction even if decode is stalled.
                        pc_q        <= redir_pc_i;
                        ifu_valid_q <= 1'b0;
                    end else if (pending_q) begin
                        // A stalled held instruction was never consumed, so return to it.
                        int_ret_pc_q <= (ifu_valid_q && !ifu_ready_i) ? ifu_pc_q : pc_q;
                        ifu_valid_q  <= 1'b0;
                        intr_ack_q   <= 1'b1;
                        pending_q    <= 1'b0;
                        state_q      <= StInt;
                    end else if (advance) begin
                        ifu_instr_q <= imem_data_i;
                        ifu_pc_q    <= pc_q;
                        ifu_valid_q <= 1'b1;
                        pc_q        <= pc_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StBoot;
                end
            endcase
        end
    end

    assign ifu_valid_o  = ifu_valid_q;
    assign ifu_instr_o  = ifu_instr_q;
    assign ifu_pc_o     = ifu_pc_q;
    assign intr_ack_o   = intr_ack_q;
    assign int_ret_pc_o = int_ret_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios followed by randomized traffic, checked
// against a transaction-level reference model through handshake and interrupt-ack queues.
module tb_instr_fetch_unit;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_INT  = 2;

    logic       clk;
    logic       rst_n;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic       ifu_valid;
    logic       ifu_ready;
    logic [7:0] ifu_instr;
    logic [7:0] ifu_pc;
    logic       redir_valid;
    logic [7:0] redir_pc;
    logic       intr_req;
    logic       intr_ack;
    logic [7:0] int_ret_pc;

    logic [7:0] mem [256];
    assign imem_data = mem[imem_addr];

    instr_fetch_unit #(
        .ADDR_W      (8),
        .DATA_W      (8),
        .RST_VEC_ADDR(8'h00),
        .INT_VEC_ADDR(8'h01)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .imem_addr_o  (imem_addr),
        .imem_data_i  (imem_data),
        .ifu_valid_o  (ifu_valid),
        .ifu_ready_i  (ifu_ready),
        .ifu_instr_o  (ifu_instr),
        .ifu_pc_o     (ifu_pc),
        .redir_valid_i(redir_valid),
        .redir_pc_i   (redir_pc),
        .intr_req_i   (intr_req),
        .intr_ack_o   (intr_ack),
        .int_ret_pc_o (int_ret_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Expected consumed instructions {pc, instr} and expected interrupt return addresses.
    logic [15:0] hs_q[$];
    logic [7:0]  ack_q[$];

    // Reference model: where the fetch stream stands after each edge.
    int         m_mode = M_BOOT;
    logic [7:0] m_pc = 8'h00;     // next address to fetch
    bit         m_hv = 1'b0;      // an instruction is on offer to decode
    logic [7:0] m_hpc = 8'h00;
    logic [7:0] m_hinstr = 8'h00;
    bit         m_pend = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm, input logic [15:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %h, expected nothing (t=%0t)", nm, act, $time);
    endtask

    // Monitor: pops an expectation whenever the DUT hands over an instruction or acks.
    logic [15:0] mon_hs;
    logic [7:0]  mon_ack;
    always @(negedge clk) begin
        if (ifu_valid === 1'b1 && ifu_ready === 1'b1) begin
            if (hs_q.size() == 0) begin
                fail_now("unexpected_handshake", {ifu_pc, ifu_instr});
            end else begin
                mon_hs = hs_q.pop_front();
                chk("handshake_pc_instr", {ifu_pc, ifu_instr}, mon_hs);
            end
        end else if (hs_q.size() != 0) begin
            mon_hs = hs_q.pop_front();
            chk("missing_handshake", {15'd0, ifu_valid === 1'b1 && ifu_ready === 1'b1}, 16'd1);
        end
        if (intr_ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                fail_now("unexpected_intr_ack", {8'h00, int_ret_pc});
            end else begin
                mon_ack = ack_q.pop_front();
                chk("int_ret_pc", {8'h00, int_ret_pc}, {8'h00, mon_ack});
            end
        end else if (ack_q.size() != 0) begin
            mon_ack = ack_q.pop_front();
            chk("missing_intr_ack", {15'd0, intr_ack === 1'b1}, 16'd1);
        end
    end

    // Apply one edge of the fetch rules to the model.
    task automatic model_step(input bit rst, input bit rdy, input bit rv, input logic [7:0] rp,
                              input bit ir);
        bit take;
        if (!rst) begin
            m_mode = M_BOOT;
            m_pc = 8'h00;
            m_hv = 1'b0;
            m_pend = 1'b0;
            return;
        end
        take = (m_mode == M_RUN) && m_pend && !rv;
        if (m_mode == M_BOOT) begin
            m_pc = mem[0];
            m_mode = M_RUN;
        end else if (m_mode == M_INT) begin
            m_pc = mem[1];
            m_mode = M_RUN;
        end else if (rv) begin
            m_pc = rp;
            m_hv = 1'b0;
        end else if (take) begin
            ack_q.push_back((m_hv && !rdy) ? m_hpc : m_pc);
            m_hv = 1'b0;
            m_mode = M_INT;
        end else if (!m_hv || rdy) begin
            m_hv = 1'b1;
            m_hpc = m_pc;
            m_hinstr = mem[m_pc];
            m_pc = m_pc + 8'd1;
        end
        if (take) m_pend = 1'b0;
        else if (ir) m_pend = 1'b1;
    endtask

    // One cycle: drive inputs, record any expected handshake, step past the edge, check state.
    task automatic drive(input bit rst, input bit rdy, input bit rv, input logic [7:0] rp,
                         input bit ir);
        logic [7:0] exp_addr;
        rst_n = rst;
        ifu_ready = rdy;
        redir_valid = rv;
        redir_pc = rp;
        intr_req = ir;
        if (m_hv && rdy) hs_q.push_back({m_hpc, m_hinstr});
        @(posedge clk);
        #1;
        model_step(rst, rdy, rv, rp, ir);
        exp_addr = (m_mode == M_BOOT) ? 8'h00 : (m_mode == M_INT) ? 8'h01 : m_pc;
        chk("ifu_valid", {15'd0, ifu_valid}, {15'd0, m_hv});
        chk("imem_addr", {8'h00, imem_addr}, {8'h00, exp_addr});
        if (m_hv) chk("held_pc_instr", {ifu_pc, ifu_instr}, {m_hpc, m_hinstr});
    endtask

    task automatic reset_checks();
        chk("rst_ifu_pc", {8'h00, ifu_pc}, 16'h0000);
        chk("rst_ifu_instr", {8'h00, ifu_instr}, 16'h0000);
        chk("rst_int_ret_pc", {8'h00, int_ret_pc}, 16'h0000);
        chk("rst_intr_ack", {15'd0, intr_ack}, 16'h0000);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        reset_checks();
    endtask

    int guard;
    int stall;
    bit r_rst, r_rdy, r_rv, r_ir;
    logic [7:0] r_rp;

    initial begin
        rst_n = 1'b0;
        ifu_ready = 1'b0;
        redir_valid = 1'b0;
        redir_pc = 8'h00;
        intr_req = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        // Boot to 0x10 and stream A1, A2, A3; valid appears on the second edge after release.
        mem[0] = 8'h10;
        mem[1] = 8'h80;
        mem[8'h10] = 8'hA1;
        mem[8'h11] = 8'hA2;
        mem[8'h12] = 8'hA3;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        // Long stall, then resume.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        // Redirect to 0x40 while stalled flushes the held instruction.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 8'h40, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        // PC wrap from 0xFE.
        mem[0] = 8'hFE;
        do_reset();
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        // Interrupt while 0x13 is held and stalled: return address is 0x13.
        mem[0] = 8'h10;
        do_reset();
        guard = 0;
        while (!(m_hv && m_hpc == 8'h13) && guard < 20) begin
            drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
            guard++;
        end
        chk("reach_pc_13", {8'h00, m_hpc}, 16'h0013);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        // Request during boot is taken once after boot.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        // Redirect beats a pending interrupt; two requests yield one interrupt returning to 0x55.
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 8'h55, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        // Reset while in the interrupt vector fetch.
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("in_int_state", 16'(m_mode), 16'(M_INT));
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        // Randomized traffic.
        stall = 0;
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom % 300) != 0;
            if (!r_rst) begin
                mem[0] = 8'($urandom);
                mem[1] = 8'($urandom);
            end
            if (stall == 0 && ($urandom % 50) == 0) stall = $urandom_range(3, 12);
            if (stall > 0) begin
                r_rdy = 1'b0;
                stall--;
            end else begin
                r_rdy = ($urandom % 4) != 0;
            end
            r_rv = ($urandom % 12) == 0;
            r_rp = 8'($urandom);
            r_ir = ($urandom % 20) == 0;
            if (m_mode == M_RUN && m_pend && !r_rv) r_ir = 1'b0;
            drive(r_rst, r_rdy, r_rv, r_rp, r_ir);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        #1;
        chk("hs_queue_drained", 16'(hs_q.size()), 16'd0);
        chk("ack_queue_drained", 16'(ack_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
